// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Multi-cycle control sequencer for a simple non-pipelined processor. Each
// instruction walks through FETCH -> REG_READ -> ALU -> [MEM] -> [REG_WRITE]
// -> PC_UPDATE. A halt instruction parks the sequencer in HALTED until reset.
// Multiplies hold the ALU stage for MUL_LATENCY cycles.
//
// Parameters
//   MUL_LATENCY      cycles spent in ALU for a multiply (legal range 1..15)
//
// Ports
//   clk              single clock, all state updates on its rising edge
//   rst              asynchronous, active-high reset
//   mem_ready        memory acknowledge for the current mem_req
//   alu_operation    decoded ALU op; `ALU_OP_MUL selects multi-cycle timing
//   instr_is_load    decoded instruction class bits; required stable from
//   instr_is_store     REG_READ through PC_UPDATE
//   instr_writes_reg
//   instr_is_halt
//   stage            current stage (`STAGE_* encoding), registered
//   mem_req          memory request (FETCH and MEM)
//   mem_write        write qualifier for mem_req (stores in MEM only)
//   instr_reg_en     instruction register load strobe (FETCH, mem_ready cycle)
//   reg_write_en     register file write strobe (REG_WRITE)
//   pc_write_en      program counter load strobe (PC_UPDATE)
//   halted           sticky halt indicator
//   instr_count      number of retired instructions, wraps at 2^32
// -----------------------------------------------------------------------------

`ifndef STAGE_FETCH
`define STAGE_FETCH     3'd0
`endif
`ifndef STAGE_REG_READ
`define STAGE_REG_READ  3'd1
`endif
`ifndef STAGE_ALU
`define STAGE_ALU       3'd2
`endif
`ifndef STAGE_MEM
`define STAGE_MEM       3'd3
`endif
`ifndef STAGE_REG_WRITE
`define STAGE_REG_WRITE 3'd4
`endif
`ifndef STAGE_PC_UPDATE
`define STAGE_PC_UPDATE 3'd5
`endif
`ifndef STAGE_HALTED
`define STAGE_HALTED    3'd6
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD      3'd0
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL      3'd2
`endif

module stage_sequencer #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ready,
  input  logic [2:0]  alu_operation,
  input  logic        instr_is_load,
  input  logic        instr_is_store,
  input  logic        instr_writes_reg,
  input  logic        instr_is_halt,
  output logic [2:0]  stage,
  output logic        mem_req,
  output logic        mem_write,
  output logic        instr_reg_en,
  output logic        reg_write_en,
  output logic        pc_write_en,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH     = `STAGE_FETCH,
    REG_READ  = `STAGE_REG_READ,
    ALU       = `STAGE_ALU,
    MEM       = `STAGE_MEM,
    REG_WRITE = `STAGE_REG_WRITE,
    PC_UPDATE = `STAGE_PC_UPDATE,
    HALTED    = `STAGE_HALTED
  } state_t;

  // Last value of the multiply counter before leaving ALU.
  localparam logic [3:0] MUL_LAST = 4'(MUL_LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] mul_count;
  logic       alu_done;
  logic       mem_ack;

  // A multiply stays in ALU until the counter reaches MUL_LAST; every other
  // operation spends exactly one cycle there.
  assign alu_done = (alu_operation != `ALU_OP_MUL) || (mul_count == MUL_LAST);

  // mem_req is low in the first cycle after reset, so a mem_ready arriving
  // then is not an acknowledge and must not advance FETCH.
  assign mem_ack = mem_req && mem_ready;

  // ---------------------------------------------------------------------------
  // Next-state function
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through this block leaves
    // state_next unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      FETCH:     if (mem_ack) state_next = REG_READ;
      REG_READ:  state_next = instr_is_halt ? HALTED : ALU;
      ALU: begin
        if (alu_done) begin
          if (instr_is_load || instr_is_store) state_next = MEM;
          else if (instr_writes_reg)           state_next = REG_WRITE;
          else                                 state_next = PC_UPDATE;
        end
      end
      // Load wins when both load and store are set.
      MEM:       if (mem_ack) state_next = instr_is_load ? REG_WRITE : PC_UPDATE;
      REG_WRITE: state_next = PC_UPDATE;
      PC_UPDATE: state_next = FETCH;
      HALTED:    state_next = HALTED;
      default:   state_next = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs. Outputs are derived from the
  // next state so they line up with the stage they belong to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      mul_count    <= '0;
      instr_count  <= '0;
      halted       <= 1'b0;
      mem_req      <= 1'b0;
      mem_write    <= 1'b0;
      reg_write_en <= 1'b0;
      pc_write_en  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state <= state_next;

      // Counter runs only while a multiply stays in ALU; anything else clears
      // it, so it is always zero on ALU entry.
      if (state == ALU && state_next == ALU) mul_count <= mul_count + 4'd1;
      else                                   mul_count <= '0;

      if (state == PC_UPDATE) instr_count <= instr_count + 32'd1;

      mem_req      <= (state_next == FETCH) || (state_next == MEM);
      mem_write    <= (state_next == MEM) && instr_is_store && !instr_is_load;
      reg_write_en <= (state_next == REG_WRITE);
      pc_write_en  <= (state_next == PC_UPDATE);
      halted       <= (state_next == HALTED);
    end
  end

  // The instruction register must capture on the same edge that sees the
  // acknowledge, so this strobe is the one output qualified by mem_ready.
  assign instr_reg_en = (state == FETCH) && mem_ack;

  assign stage = state;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Self-checking bench for stage_sequencer. A reference model turns each
// instruction's class bits and memory wait counts into the expected list of
// stages; per-cycle outputs are derived from that list. A second instance
// with MUL_LATENCY=1 covers the short-multiply case.
// -----------------------------------------------------------------------------

`timescale 1ns/1ps

`ifndef STAGE_FETCH
`define STAGE_FETCH     3'd0
`endif
`ifndef STAGE_REG_READ
`define STAGE_REG_READ  3'd1
`endif
`ifndef STAGE_ALU
`define STAGE_ALU       3'd2
`endif
`ifndef STAGE_MEM
`define STAGE_MEM       3'd3
`endif
`ifndef STAGE_REG_WRITE
`define STAGE_REG_WRITE 3'd4
`endif
`ifndef STAGE_PC_UPDATE
`define STAGE_PC_UPDATE 3'd5
`endif
`ifndef STAGE_HALTED
`define STAGE_HALTED    3'd6
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD      3'd0
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL      3'd2
`endif

module tb_stage_sequencer;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ready = 1'b0;
  logic [2:0]  alu_operation = `ALU_OP_ADD;
  logic        instr_is_load = 1'b0;
  logic        instr_is_store = 1'b0;
  logic        instr_writes_reg = 1'b0;
  logic        instr_is_halt = 1'b0;

  logic [2:0]  stage, stage1;
  logic        mem_req, mem_write, instr_reg_en, reg_write_en, pc_write_en, halted;
  logic        mem_req1, mem_write1, instr_reg_en1, reg_write_en1, pc_write_en1, halted1;
  logic [31:0] instr_count, instr_count1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_count = 32'd0;

  // One expected cycle: the stage and how mem_ready is driven in it
  // (0 = low wait cycle, 1 = acknowledge, 2 = don't care, randomised).
  typedef struct {
    logic [2:0] st;
    int         rdy_mode;
  } step_t;

  step_t seq[$];

  stage_sequencer #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .alu_operation(alu_operation),
    .instr_is_load(instr_is_load), .instr_is_store(instr_is_store),
    .instr_writes_reg(instr_writes_reg), .instr_is_halt(instr_is_halt),
    .stage(stage), .mem_req(mem_req), .mem_write(mem_write),
    .instr_reg_en(instr_reg_en), .reg_write_en(reg_write_en),
    .pc_write_en(pc_write_en), .halted(halted), .instr_count(instr_count)
  );

  stage_sequencer #(.MUL_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .alu_operation(alu_operation),
    .instr_is_load(instr_is_load), .instr_is_store(instr_is_store),
    .instr_writes_reg(instr_writes_reg), .instr_is_halt(instr_is_halt),
    .stage(stage1), .mem_req(mem_req1), .mem_write(mem_write1),
    .instr_reg_en(instr_reg_en1), .reg_write_en(reg_write_en1),
    .pc_write_en(pc_write_en1), .halted(halted1), .instr_count(instr_count1)
  );

  always #5 clk = ~clk;

  // {stage, mem_req, mem_write, instr_reg_en, reg_write_en, pc_write_en, halted}
  function automatic logic [8:0] observed();
    return {stage, mem_req, mem_write, instr_reg_en, reg_write_en, pc_write_en, halted};
  endfunction

  function automatic logic [8:0] expected(input logic [2:0] st, input logic rdy,
                                          input logic ld, input logic sto);
    logic mr, mw, ire, rwe, pwe, h;
    mr  = (st == `STAGE_FETCH) || (st == `STAGE_MEM);
    mw  = (st == `STAGE_MEM) && sto && !ld;
    ire = (st == `STAGE_FETCH) && rdy;
    rwe = (st == `STAGE_REG_WRITE);
    pwe = (st == `STAGE_PC_UPDATE);
    h   = (st == `STAGE_HALTED);
    return {st, mr, mw, ire, rwe, pwe, h};
  endfunction

  // Reference model: the stage list an instruction must walk through.
  task automatic build_seq(input bit ld, input bit sto, input bit wr, input bit hl,
                           input bit mul, input int fw, input int mw);
    seq.delete();
    repeat (fw) seq.push_back('{`STAGE_FETCH, 0});
    seq.push_back('{`STAGE_FETCH, 1});
    seq.push_back('{`STAGE_REG_READ, 2});
    if (hl) begin
      seq.push_back('{`STAGE_HALTED, 2});
      return;
    end
    repeat (mul ? MUL_LAT : 1) seq.push_back('{`STAGE_ALU, 2});
    if (ld || sto) begin
      repeat (mw) seq.push_back('{`STAGE_MEM, 0});
      seq.push_back('{`STAGE_MEM, 1});
    end
    if (ld || (!sto && wr)) seq.push_back('{`STAGE_REG_WRITE, 2});
    seq.push_back('{`STAGE_PC_UPDATE, 2});
  endtask

  // Precondition: just after a rising edge with the DUT in FETCH, mem_req=1.
  task automatic run_instr(input string name, input bit ld, input bit sto,
                           input bit wr, input bit hl, input bit mul,
                           input int fw, input int mw, input bit tie_high);
    logic [8:0] exp_v;
    logic [2:0] op;
    instr_is_load    = ld;
    instr_is_store   = sto;
    instr_writes_reg = wr;
    instr_is_halt    = hl;
    op = 3'($urandom_range(0, 7));
    if (op == `ALU_OP_MUL) op = `ALU_OP_ADD;
    alu_operation = mul ? `ALU_OP_MUL : op;
    build_seq(ld, sto, wr, hl, mul, fw, mw);
    for (int i = 0; i < seq.size(); i++) begin
      if (seq[i].rdy_mode == 2) mem_ready = tie_high ? 1'b1 : 1'($urandom_range(0, 1));
      else                      mem_ready = 1'(seq[i].rdy_mode);
      @(negedge clk);
      exp_v = expected(seq[i].st, mem_ready, ld, sto);
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, i, observed(), exp_v);
      end
      @(posedge clk);
      #1;
    end
    if (!hl) model_count = model_count + 32'd1;
    checks++;
    if (instr_count !== model_count || stage !== (hl ? `STAGE_HALTED : `STAGE_FETCH)) begin
      errors++;
      $display("FAIL %s end: count %0d stage %0d expected count %0d stage %0d", name,
               instr_count, stage, model_count, hl ? `STAGE_HALTED : `STAGE_FETCH);
    end
  endtask

  // Asynchronous reset assert/release; leaves the DUT in FETCH with mem_req=1,
  // just after a rising edge. mem_ready is held high throughout to show the
  // first post-reset cycle does not treat it as an acknowledge.
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    model_count = 32'd0;
    checks++;
    if ({observed(), instr_count} !== {`STAGE_FETCH, 6'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_assert: got %b count %0d", observed(), instr_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (observed() !== {`STAGE_FETCH, 6'b0}) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", observed(), {`STAGE_FETCH, 6'b0});
    end
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== {`STAGE_FETCH, 1'b1, 1'b0, 1'b1, 3'b0}) begin
      errors++;
      $display("FAIL reset_first_fetch: got %b expected %b", observed(),
               {`STAGE_FETCH, 1'b1, 1'b0, 1'b1, 3'b0});
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    run_instr("add_tied", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_mul();
    int  a4 = 0, a1 = 0;
    bit  d4 = 0, d1 = 0;
    do_reset();
    instr_is_load = 1'b0; instr_is_store = 1'b0;
    instr_writes_reg = 1'b0; instr_is_halt = 1'b0;
    alu_operation = `ALU_OP_MUL;
    mem_ready = 1'b1;
    for (int c = 0; c < 40 && !(d4 && d1); c++) begin
      @(negedge clk);
      if (!d4) begin
        if (stage == `STAGE_ALU) a4++;
        if (stage == `STAGE_PC_UPDATE) d4 = 1;
      end
      if (!d1) begin
        if (stage1 == `STAGE_ALU) a1++;
        if (stage1 == `STAGE_PC_UPDATE) d1 = 1;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!(d4 && d1)) begin
      errors++;
      $display("FAIL mul_timeout: done4 %0d done1 %0d required 1 1", d4, d1);
    end
    checks++;
    if (a4 !== MUL_LAT) begin
      errors++;
      $display("FAIL mul_latency4: alu cycles %0d expected %0d", a4, MUL_LAT);
    end
    checks++;
    if (a1 !== 1) begin
      errors++;
      $display("FAIL mul_latency1: alu cycles %0d expected 1", a1);
    end
    do_reset();
  endtask

  task automatic test_load_store();
    run_instr("load_wait3",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 1'b0);
    run_instr("store",       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 2, 1'b0);
    run_instr("load_store",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
    run_instr("store_tied",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    run_instr("nop",         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_instr("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_wrap();
    #1;
    force dut.instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count;
    model_count = 32'hFFFF_FFFF;
    run_instr("wrap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  // Abandon a load in MEM or a multiply mid-count with an asynchronous reset.
  task automatic test_reset_mid(input bit mul_case);
    int  seen = 0;
    bit  hit = 0;
    logic [2:0] target;
    target = mul_case ? `STAGE_ALU : `STAGE_MEM;
    instr_is_load = !mul_case; instr_is_store = 1'b0;
    instr_writes_reg = 1'b1; instr_is_halt = 1'b0;
    alu_operation = mul_case ? `ALU_OP_MUL : `ALU_OP_ADD;
    for (int c = 0; c < 30 && !hit; c++) begin
      mem_ready = (stage == `STAGE_MEM) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (stage == target) seen++;
      if (seen == 2) hit = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach: target stage %0d not reached, stage %0d", target, stage);
    end
    #3;
    rst = 1'b1;
    #1;
    model_count = 32'd0;
    checks++;
    if ({observed(), instr_count} !== {`STAGE_FETCH, 6'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_%s: got %b count %0d expected %b count 0",
               mul_case ? "mul" : "mem", observed(), instr_count, {`STAGE_FETCH, 6'b0});
    end
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_instr(mul_case ? "after_mul_reset" : "after_mem_reset",
              1'b0, 1'b0, 1'b1, 1'b0, mul_case, 0, 0, 1'b0);
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    run_instr("pre_halt", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr("halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
    frozen = model_count;
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0];
      @(negedge clk);
      checks++;
      if (observed() !== {`STAGE_HALTED, 5'b0, 1'b1}) begin
        errors++;
        $display("FAIL halted_hold cycle %0d: got %b expected %b", c, observed(),
                 {`STAGE_HALTED, 5'b0, 1'b1});
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (instr_count !== frozen) begin
      errors++;
      $display("FAIL halt_count: got %0d expected %0d", instr_count, frozen);
    end
    do_reset();
    run_instr("after_halt", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_load_store();
    test_random();
    test_wrap();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter MUL_LATENCY, default 4, meaning cycles spent in ALU stage for a multiply (legal range 1-15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port mem_ready, input, 1, memory acknowledge for the current mem_req.
REQ-005 The block SHALL have port alu_operation, input, 3, decoded ALU op; `ALU_OP_MUL selects multi-cycle timing.
REQ-006 The block SHALL have ports instr_is_load, instr_is_store, instr_writes_reg, instr_is_halt, each input, 1, decoded instruction class bits.
REQ-007 The block SHALL have port stage, output, 3, current stage, using the `STAGE_* encodings from arch_defines.v.
REQ-008 The block SHALL have ports mem_req and mem_write, each output, 1: memory request, and write qualifier for that request.
REQ-009 The block SHALL have ports instr_reg_en, reg_write_en and pc_write_en, each output, 1, single-cycle load strobes.
REQ-010 The block SHALL have port halted, output, 1, sticky halt indicator.
REQ-011 The block SHALL have port instr_count, output, 32, count of retired instructions.

Function
REQ-012 States SHALL be FETCH, REG_READ, ALU, MEM, REG_WRITE, PC_UPDATE, HALTED; stage output = current state, registered, with no combinational path from inputs.
REQ-013 FETCH: mem_req=1, mem_write=0; hold until mem_ready=1; in the mem_ready cycle instr_reg_en=1; next REG_READ.
REQ-014 REG_READ: one cycle; next HALTED if instr_is_halt, else ALU.
REQ-015 ALU: one cycle if alu_operation != `ALU_OP_MUL, else exactly MUL_LATENCY cycles, tracked by a 4-bit counter cleared on ALU entry.
REQ-016 ALU exit priority: instr_is_load or instr_is_store -> MEM; else instr_writes_reg -> REG_WRITE; else PC_UPDATE.
REQ-017 MEM: mem_req=1; mem_write=instr_is_store AND NOT instr_is_load; hold until mem_ready; then a load goes to REG_WRITE and a store goes to PC_UPDATE.
REQ-018 If load and store are both set, the instruction SHALL be treated as a load.
REQ-019 REG_WRITE: reg_write_en=1 for exactly one cycle; next PC_UPDATE.
REQ-020 PC_UPDATE: pc_write_en=1 for one cycle; instr_count increments by 1, wrapping 32'hFFFFFFFF -> 0; next FETCH.
REQ-021 HALTED: absorbing until rst; halted=1; all strobes and mem_req=0; instr_count frozen; a halt instruction is not counted.
REQ-022 mem_ready outside FETCH/MEM SHALL be ignored; mem_ready held high SHALL give a one-cycle FETCH and a one-cycle MEM.
REQ-023 Decoded inputs SHALL be sampled only in the state that uses them; they are required stable from REG_READ through PC_UPDATE.
REQ-024 Minimum instruction latency (non-MUL, no memory, no writeback, zero-wait memory) SHALL be 4 cycles: FETCH, REG_READ, ALU, PC_UPDATE.

Reset
REQ-025 rst=1 SHALL immediately force state FETCH, MUL counter 0, instr_count 0, halted 0, and instr_reg_en, reg_write_en, pc_write_en and mem_write to 0, independent of clk.
REQ-026 During reset mem_req SHALL be 0; it first rises in the cycle after rst deasserts.
REQ-027 Reset asserted mid-instruction (any state, including a pending mem_req or a partial MUL count) SHALL abandon that instruction with no strobe emitted.

Verification
REQ-028 ADD, writes_reg=1, mem_ready tied high -> stage sequence FETCH, REG_READ, ALU, REG_WRITE, PC_UPDATE, FETCH; instr_count 0 -> 1.
REQ-029 MUL with MUL_LATENCY=4 -> stage=ALU for exactly 4 cycles; with MUL_LATENCY=1 -> 1 cycle.
REQ-030 Load with mem_ready low 3 cycles in MEM -> mem_req=1 and mem_write=0 held 4 cycles; then REG_WRITE with reg_write_en pulse; store -> mem_write=1, then directly PC_UPDATE.
REQ-031 Halt instruction -> REG_READ then HALTED; halted=1; instr_count unchanged over 20 further cycles with mem_ready toggling.
REQ-032 instr_count preset to 32'hFFFFFFFF via 2^32-1 retired instructions (or forced in the bench) -> next PC_UPDATE yields 0.
REQ-033 rst pulsed asynchronously mid-MEM and mid-MUL -> outputs reach reset values before the next clk edge; the following instruction runs normally.
